// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: buffers one transmit request per source (2-byte ALU
// result, 1-byte register-file read), arbitrates round-robin between them and
// hands bytes to UART_TX one frame at a time over the TX_Data_valid/busy
// handshake. An ALU pair is always sent low byte first and never interleaved.
module uart_tx_scheduler #(
    parameter int Data_width = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2*Data_width-1:0] ALU_OUT,
    input  logic                    ALU_OUT_Valid,
    input  logic [Data_width-1:0]   RF_RdData,
    input  logic                    RF_RdData_Valid,
    input  logic                    busy,
    output logic [Data_width-1:0]   TX_P_DATA,
    output logic                    TX_Data_valid,
    output logic                    ALU_ovf,
    output logic                    RF_ovf,
    output logic                    sched_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    // last_grant encoding: which source won the most recent grant
    localparam logic LG_ALU = 1'b0;
    localparam logic LG_RF  = 1'b1;

    state_t                  r_state;
    logic                    r_alu_pend;
    logic                    r_rf_pend;
    logic [2*Data_width-1:0] r_alu_data;
    logic [Data_width-1:0]   r_rf_data;
    logic [Data_width-1:0]   r_alu_hi;
    logic                    r_last_grant;
    logic                    r_bytes_left;
    logic [Data_width-1:0]   r_tx_data;
    logic                    r_tx_valid;
    logic                    r_alu_ovf;
    logic                    r_rf_ovf;

    logic                    w_can_grant;
    logic                    w_grant_alu;
    logic                    w_grant_rf;
    logic                    w_alu_load;
    logic                    w_rf_load;

    // A grant only happens from IDLE while the line is free; ties go to the
    // source that did not win last time.
    assign w_can_grant = (r_state == S_IDLE) && !busy;
    assign w_grant_alu = w_can_grant && r_alu_pend && (!r_rf_pend  || (r_last_grant == LG_RF));
    assign w_grant_rf  = w_can_grant && r_rf_pend  && (!r_alu_pend || (r_last_grant == LG_ALU));

    // A strobe is accepted into an empty slot, or into a slot being vacated
    // by a grant on the same edge.
    assign w_alu_load  = ALU_OUT_Valid   && (!r_alu_pend || w_grant_alu);
    assign w_rf_load   = RF_RdData_Valid && (!r_rf_pend  || w_grant_rf);

    // Slot payloads; only meaningful while the matching pend flag is set.
    // The ALU high byte is copied out at grant so a same-edge reload of the
    // slot cannot corrupt the pair already in flight.
    always_ff @(posedge CLK) begin
        if (w_alu_load) begin
            r_alu_data <= ALU_OUT;
        end
        if (w_rf_load) begin
            r_rf_data <= RF_RdData;
        end
        if (w_grant_alu) begin
            r_alu_hi <= r_alu_data[2*Data_width-1:Data_width];
        end
    end

    // Pend flags and registered overflow pulses for dropped strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_alu_pend <= 1'b0;
            r_rf_pend  <= 1'b0;
            r_alu_ovf  <= 1'b0;
            r_rf_ovf   <= 1'b0;
        end else begin
            if (w_alu_load) begin
                r_alu_pend <= 1'b1;
            end else if (w_grant_alu) begin
                r_alu_pend <= 1'b0;
            end
            if (w_rf_load) begin
                r_rf_pend <= 1'b1;
            end else if (w_grant_rf) begin
                r_rf_pend <= 1'b0;
            end
            r_alu_ovf <= ALU_OUT_Valid   && !w_alu_load;
            r_rf_ovf  <= RF_RdData_Valid && !w_rf_load;
        end
    end

    // Transmit FSM: grant, strobe, then follow busy high and low per frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_last_grant <= LG_RF;
            r_bytes_left <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx_valid <= 1'b0;
                    if (w_grant_alu) begin
                        r_tx_data    <= r_alu_data[Data_width-1:0];
                        r_bytes_left <= 1'b1;
                        r_last_grant <= LG_ALU;
                        r_tx_valid   <= 1'b1;
                        r_state      <= S_SEND;
                    end else if (w_grant_rf) begin
                        r_tx_data    <= r_rf_data;
                        r_bytes_left <= 1'b0;
                        r_last_grant <= LG_RF;
                        r_tx_valid   <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    r_tx_valid <= 1'b0;
                    if (busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    r_tx_valid <= 1'b0;
                    if (!busy) begin
                        if (r_bytes_left) begin
                            r_tx_data    <= r_alu_hi;
                            r_bytes_left <= 1'b0;
                            r_tx_valid   <= 1'b1;
                            r_state      <= S_SEND;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign TX_P_DATA     = r_tx_data;
    assign TX_Data_valid = r_tx_valid;
    assign ALU_ovf       = r_alu_ovf;
    assign RF_ovf        = r_rf_ovf;
    assign sched_busy    = r_alu_pend | r_rf_pend | (r_state != S_IDLE);

endmodule
